// File: rtl/req_pending_dispatch_pkg.sv
// req_pkg: shared widths and types for the request dispatch slice
package req_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] req_idx_t;
endpackage

// File: rtl/req_pending_dispatch_lowest_set_index.sv
// lowest_set_index: index of the lowest set bit of a request vector, plus any-set flag
module lowest_set_index
  import req_pkg::*;
(
  input  req_vec_t vec,
  output req_idx_t idx,
  output logic     any
);
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (vec[i]) idx = req_idx_t'(i);
  end
  assign any = |vec;
endmodule

// File: rtl/req_pending_dispatch.sv
// req_pending_dispatch: sticky request capture with fixed lowest-index-first valid/ready dispatch
module req_pending_dispatch
  import req_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N),
  parameter int EDGE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             overflow
);
  localparam logic IDLE    = 1'b0;
  localparam logic PRESENT = 1'b1;
  logic [N-1:0] req_q, rise, clr, cand;
  logic         acc, load, any, state, state_next;
  req_idx_t     win;
  assign rise = (EDGE != 0) ? (req_in & ~req_q) : req_in;
  assign acc  = state & out_ready;
  assign clr  = acc ? ({{(N-1){1'b0}}, 1'b1} << out_idx) : '0;
  assign cand = pending & ~clr & mask;
  lowest_set_index u_lsi (.vec(cand), .idx(win), .any(any));
  // A held index is only replaced once it has been accepted
  assign load = enable & any & (~state | out_ready);
  always_comb state_next = load ? PRESENT : (acc ? IDLE : state);
  assign out_valid = state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      out_idx  <= '0;
    end else begin
      req_q    <= req_in;
      pending  <= (pending & ~clr) | rise;
      overflow <= |(rise & pending & ~clr);
      state    <= state_next;
      if (load) out_idx <= win;
    end
  end
endmodule

// File: tb/tb_req_pending_dispatch.sv
// tb_req_pending_dispatch: directed checks of capture, priority, handshake, masking and reset
module tb_req_pending_dispatch;
  logic        clk = 1'b0;
  logic        rst_n, enable, out_ready, out_valid, overflow;
  logic [15:0] req_in, mask, pending;
  logic [3:0]  out_idx;
  int          passed = 0, total = 0, cnt;
  req_pending_dispatch dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_in(req_in), .mask(mask),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .pending(pending), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1; req_in = '0; mask = 16'hFFFF;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_valid", out_valid, 0);
      chk("idle_pending", pending, 0);
      chk("idle_ovf", overflow, 0);
    end
    req_in = 16'h0050;
    step(1);
    req_in = '0;
    chk("t2_pend", pending, 16'h0050);
    chk("t2_valid0", out_valid, 0);
    step(1);
    chk("t2_v4", out_valid, 1);
    chk("t2_idx4", out_idx, 4);
    step(1);
    chk("t2_v6", out_valid, 1);
    chk("t2_idx6", out_idx, 6);
    chk("t2_pend6", pending, 16'h0040);
    step(1);
    chk("t2_done_v", out_valid, 0);
    chk("t2_done_p", pending, 0);
    out_ready = 1'b0;
    req_in = 16'h0200;
    step(1);
    req_in = '0;
    step(1);
    chk("t3_v9", out_valid, 1);
    chk("t3_idx9", out_idx, 9);
    req_in = 16'h0004;
    step(1);
    req_in = '0;
    chk("t3_hold_p", pending, 16'h0204);
    chk("t3_hold_i", out_idx, 9);
    step(1);
    chk("t3_hold_i2", out_idx, 9);
    chk("t3_hold_v2", out_valid, 1);
    out_ready = 1'b1;
    step(1);
    chk("t3_idx2", out_idx, 2);
    chk("t3_v2", out_valid, 1);
    chk("t3_p2", pending, 16'h0004);
    step(1);
    chk("t3_done_v", out_valid, 0);
    chk("t3_done_p", pending, 0);
    mask = 16'hFFF7;
    req_in = 16'h0008;
    step(1);
    req_in = '0;
    step(1);
    chk("t4_pend", pending, 16'h0008);
    chk("t4_valid0", out_valid, 0);
    mask = 16'hFFFF;
    step(1);
    chk("t4_v3", out_valid, 1);
    chk("t4_idx3", out_idx, 3);
    step(1);
    chk("t4_done_p", pending, 0);
    chk("t4_done_v", out_valid, 0);
    req_in = 16'h0020;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (i == 3) req_in = '0;
      if (out_valid && out_ready) cnt++;
    end
    chk("t5_one_dispatch", cnt, 1);
    chk("t5_pend0", pending, 0);
    out_ready = 1'b0;
    req_in = 16'h0020;
    step(1);
    req_in = '0;
    chk("t5_ovf_none", overflow, 0);
    step(1);
    chk("t5_v5", out_valid, 1);
    chk("t5_idx5", out_idx, 5);
    req_in = 16'h0020;
    step(1);
    req_in = '0;
    chk("t5_ovf_pulse", overflow, 1);
    step(1);
    chk("t5_ovf_clear", overflow, 0);
    out_ready = 1'b1;
    step(2);
    chk("t5_drain_p", pending, 0);
    chk("t5_drain_v", out_valid, 0);
    out_ready = 1'b0;
    req_in = 16'h8001;
    step(1);
    req_in = '0;
    step(1);
    chk("t6_v", out_valid, 1);
    chk("t6_idx0", out_idx, 0);
    chk("t6_p", pending, 16'h8001);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("t6_rst_v", out_valid, 0);
    chk("t6_rst_p", pending, 0);
    chk("t6_rst_i", out_idx, 0);
    chk("t6_rst_o", overflow, 0);
    out_ready = 1'b1;
    step(3);
    chk("t6_after_v", out_valid, 0);
    chk("t6_after_p", pending, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
